// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART line receiver with configurable framing and a
// first-word-fall-through receive FIFO.
//   clock, reset   : single clock domain, asynchronous active-high reset
//   rx             : serial line, idles high, asynchronous to clock
//   rd_en          : pops the FIFO head when valid
//   readdata/valid : FIFO head (0 when empty) and not-empty flag
//   count          : FIFO occupancy
//   done           : one-cycle pulse per completed frame
//   parity_err, frame_err, overrun : one-cycle error pulses aligned with done
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          readdata,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          done,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitn_q, bitn_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;
    logic                 perr_pulse_q, perr_pulse_d;
    logic                 ferr_pulse_q, ferr_pulse_d;
    logic                 ovr_q, ovr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic rx_meta_q, rx_s;
    logic tick, half_tick, pop, push, ferr_now;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    assign tick      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (cnt_q == CNT_W'(HALF - 1));
    assign pop       = rd_en && (count_q != CW'(0));

    // Frame FSM: next state, sampling and end-of-frame decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bitn_d       = bitn_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        done_d       = 1'b0;
        perr_pulse_d = 1'b0;
        ferr_pulse_d = 1'b0;
        ovr_d        = 1'b0;
        push         = 1'b0;
        ferr_now     = ferr_q | ~rx_s;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                    bitn_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    cnt_d   = '0;
                    // A high line at mid-start means the edge was a glitch
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bitn_q == BIT_W'(DATA_BITS - 1)) begin
                        bitn_d  = '0;
                        state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bitn_d = bitn_q + BIT_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    cnt_d   = '0;
                    // Even: data+parity must XOR to 0; odd: to 1
                    perr_d  = (^{shreg_q, rx_s}) ^ (PARITY == 1);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_d  = '0;
                    ferr_d = ferr_now;
                    if (bitn_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (ferr_now) begin
                            ferr_pulse_d = 1'b1;
                            state_d      = ST_BREAK;
                        end else if ((count_q == CW'(FIFO_DEPTH)) && !pop) begin
                            ovr_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            push         = 1'b1;
                            perr_pulse_d = perr_q;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        bitn_d = bitn_q + BIT_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bitn_q       <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            done_q       <= 1'b0;
            perr_pulse_q <= 1'b0;
            ferr_pulse_q <= 1'b0;
            ovr_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitn_q       <= bitn_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            done_q       <= done_d;
            perr_pulse_q <= perr_pulse_d;
            ferr_pulse_q <= ferr_pulse_d;
            ovr_q        <= ovr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates what is visible
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign valid      = (count_q != CW'(0));
    assign readdata   = valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign done       = done_q;
    assign parity_err = perr_pulse_q;
    assign frame_err  = ferr_pulse_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: dut0 is 8N1, dut1 is 7 data bits, even parity,
// 2 stop bits. A queue model predicts FIFO contents and end-of-frame pulses.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] rx;
    logic [1:0] rd_en;
    wire  [7:0] rdata0;
    wire  [6:0] rdata1;
    wire  [2:0] cnt0, cnt1;
    wire  [1:0] valid, done, perr, ferr, ovr;

    always #5 clock = ~clock;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH)) dut0 (
        .clock(clock), .reset(reset), .rx(rx[0]), .rd_en(rd_en[0]),
        .readdata(rdata0), .valid(valid[0]), .count(cnt0), .done(done[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                   .FIFO_DEPTH(DEPTH)) dut1 (
        .clock(clock), .reset(reset), .rx(rx[1]), .rd_en(rd_en[1]),
        .readdata(rdata1), .valid(valid[1]), .count(cnt1), .done(done[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

    int vectors = 0;
    int miscompares = 0;

    logic       line [2][$];   // per-cycle rx levels still to drive
    logic [8:0] fq   [2][$];   // expected FIFO contents, head first
    int         cd [2];        // edges left until the frame-end sample
    logic [8:0] f_data [2];
    bit         f_fe [2], f_pe [2];
    bit         e_done [2], e_perr [2], e_ferr [2], e_ovr [2];

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [31:0] head(input int d);
        if (fq[d].size() > 0) return 32'(fq[d][0]);
        return 32'd0;
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] c, r;
            c = (d == 0) ? 32'(cnt0) : 32'(cnt1);
            r = (d == 0) ? 32'(rdata0) : 32'(rdata1);
            chk("valid", d, 32'(valid[d]), 32'(fq[d].size() != 0));
            chk("count", d, c, 32'(fq[d].size()));
            chk("readdata", d, r, head(d));
            chk("done", d, 32'(done[d]), 32'(e_done[d]));
            chk("parity_err", d, 32'(perr[d]), 32'(e_perr[d]));
            chk("frame_err", d, 32'(ferr[d]), 32'(e_ferr[d]));
            chk("overrun", d, 32'(ovr[d]), 32'(e_ovr[d]));
        end
    endtask

    // One clock: drive rx, update the model at the edge, check at negedge
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            if (line[d].size() > 0) rx[d] = line[d].pop_front();
            else rx[d] = 1'b1;
        end
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            e_done[d] = 0; e_perr[d] = 0; e_ferr[d] = 0; e_ovr[d] = 0;
            if (!reset) begin
                if (rd_en[d] && fq[d].size() > 0) void'(fq[d].pop_front());
                if (cd[d] > 0) begin
                    cd[d]--;
                    if (cd[d] == 0) begin
                        e_done[d] = 1;
                        if (f_fe[d]) e_ferr[d] = 1;
                        else if (fq[d].size() == DEPTH) e_ovr[d] = 1;
                        else begin
                            fq[d].push_back(f_data[d]);
                            e_perr[d] = f_pe[d];
                        end
                    end
                end
            end
        end
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_bit(input int d, input logic b);
        repeat (CPB) line[d].push_back(b);
    endtask

    // Queue a frame on dut d; flip inverts the parity bit (dut1 only)
    task automatic build(input int d, input logic [8:0] data, input bit flip,
                         input logic [1:0] stops, input int extra_low);
        int nd, ns, k;
        logic pb;
        nd = (d == 0) ? 8 : 7;
        ns = (d == 0) ? 1 : 2;
        push_bit(d, 1'b0);
        for (int i = 0; i < nd; i++) push_bit(d, data[i]);
        if (d == 1) begin
            pb = 1'($countones(data[6:0]) % 2) ^ flip;
            push_bit(d, pb);
        end
        for (int s = 0; s < ns; s++) push_bit(d, stops[s]);
        repeat (extra_low) line[d].push_back(1'b0);
        k = nd + ((d == 1) ? 1 : 0) + ns;
        cd[d]     = 3 + HALF + k * CPB;
        f_data[d] = (d == 0) ? {1'b0, data[7:0]} : {2'b00, data[6:0]};
        f_fe[d]   = (d == 0) ? !stops[0] : !(stops[0] && stops[1]);
        f_pe[d]   = flip;
    endtask

    task automatic send(input int d, input logic [8:0] data, input bit flip,
                        input logic [1:0] stops, input int extra_low,
                        input bit pop_at_end, input bit rnd_rd);
        build(d, data, flip, stops, extra_low);
        while (line[d].size() > 0) begin
            if (pop_at_end) rd_en[d] = (cd[d] == 1);
            else if (rnd_rd) rd_en[d] = ($urandom_range(0, 3) == 0);
            step();
        end
        if (pop_at_end || rnd_rd) rd_en[d] = 1'b0;
        chk("frame_end_reached", d, 32'(cd[d]), 32'd0);
    endtask

    // Pops everything, then keeps rd_en high on an empty FIFO
    task automatic drain(input int d);
        rd_en[d] = 1'b1;
        repeat (DEPTH + 2) step();
        rd_en[d] = 1'b0;
        chk("drained_valid", d, 32'(valid[d]), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 0, 32'(valid[0]), 32'd0);
        chk("rst_count", 0, 32'(cnt0), 32'd0);
        chk("rst_readdata", 0, 32'(rdata0), 32'd0);
        chk("rst_count", 1, 32'(cnt1), 32'd0);
        chk("rst_readdata", 1, 32'(rdata1), 32'd0);
        chk("rst_pulses", 0, 32'({done[0], perr[0], ferr[0], ovr[0]}), 32'd0);
        chk("rst_pulses", 1, 32'({done[1], perr[1], ferr[1], ovr[1]}), 32'd0);
        for (int d = 0; d < 2; d++) begin
            fq[d].delete();
            line[d].delete();
            cd[d] = 0;
            rd_en[d] = 1'b0;
        end
        idle(2);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1);
    end

    initial begin
        logic [8:0] data;
        logic [1:0] stops;
        bit flip;
        reset = 1'b0;
        rx    = 2'b11;
        rd_en = 2'b00;
        cd[0] = 0;
        cd[1] = 0;
        #1;
        do_reset();

        // Five back-to-back frames, no reads: fifth overruns
        send(0, 9'h0AA, 0, 2'b11, 0, 0, 0);
        send(0, 9'h0AB, 0, 2'b11, 0, 0, 0);
        send(0, 9'h0AC, 0, 2'b11, 0, 0, 0);
        send(0, 9'h0AD, 0, 2'b11, 0, 0, 0);
        chk("count_after_4", 0, 32'(cnt0), 32'd4);
        send(0, 9'h0AF, 0, 2'b11, 0, 0, 0);
        chk("head_after_overrun", 0, 32'(rdata0), 32'h0AA);
        drain(0);

        // Full FIFO with a pop on the frame-end edge: no overrun
        for (int i = 0; i < 4; i++) send(0, 9'($urandom_range(0, 255)), 0, 2'b11, 0, 0, 0);
        send(0, 9'h05A, 0, 2'b11, 0, 1, 0);
        chk("count_full_pop", 0, 32'(cnt0), 32'd4);
        drain(0);

        // Stop bit low, line held low, then a clean frame
        send(0, 9'h03C, 0, 2'b00, 3 * CPB, 0, 0);
        idle(CPB);
        send(0, 9'h012, 0, 2'b11, 0, 0, 0);
        chk("after_break", 0, 32'(rdata0), 32'h012);
        drain(0);

        // Start glitch shorter than half a bit
        repeat (CPB / 4) line[0].push_back(1'b0);
        idle(CPB / 4 + 2 * CPB);
        send(0, 9'h081, 0, 2'b11, 0, 0, 0);
        chk("after_glitch", 0, 32'(rdata0), 32'h081);
        drain(0);

        // Even parity: good then bad parity bit (still stored)
        send(1, 9'h055, 0, 2'b11, 0, 0, 0);
        send(1, 9'h055, 1, 2'b11, 0, 0, 0);
        chk("parity_stored", 1, 32'(cnt1), 32'd2);
        drain(1);

        // Random traffic with random reads
        repeat (16) send(0, 9'($urandom_range(0, 255)), 0, 2'b11, 0, 0, 1);
        drain(0);
        repeat (16) begin
            data  = 9'($urandom_range(0, 127));
            flip  = ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send(1, data, flip, stops, 0, 0, 1);
            idle(CPB);
        end
        drain(1);

        // Reset mid-data with two entries queued
        send(0, 9'h011, 0, 2'b11, 0, 0, 0);
        send(0, 9'h022, 0, 2'b11, 0, 0, 0);
        build(0, 9'h09C, 0, 2'b11, 0);
        idle(3 * CPB + HALF);
        do_reset();
        idle(CPB);
        send(0, 9'h0F0, 0, 2'b11, 0, 0, 0);
        chk("after_reset_frame", 0, 32'(rdata0), 32'h0F0);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
